header_dispatch: RTL and testbench

HEADER_DISPATCH -- requirements
Module: header_dispatch

---
 rtl/header_dispatch.sv | 127 ++++++++++++
 tb/tb_header_dispatch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/header_dispatch.sv
// Descriptor FIFO in front of the field unit, with a drain-then-write interlock for instruction-memory rewrites.
// Optional same-cycle bypass when empty: define HEADER_DISPATCH_BYPASS_EN.
module header_dispatch #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_pdr_id,
  input  logic [DATA_WIDTH-1:0]   in_header,
  input  logic                    in_bitmap,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_pdr_id,
  output logic [DATA_WIDTH-1:0]   out_header,
  output logic                    out_bitmap,
  input  logic                    cfg_req,
  input  logic [ADDR_WIDTH-1:0]   cfg_addr,
  input  logic [DATA_WIDTH+3:0]   cfg_data,
  output logic                    cfg_ack,
  output logic                    WE,
  output logic [ADDR_WIDTH-1:0]   W_ADDR,
  output logic [DATA_WIDTH+3:0]   WD,
  output logic [DEPTH_LOG2:0]     count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned EW    = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int unsigned CFGW  = DATA_WIDTH + 4;

  typedef enum logic [1:0] {RUN, DRAIN, WRITE} state_t;

  state_t            r_state;
  logic [EW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_we;
  logic              r_ack;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [CFGW-1:0]   r_wd;

  logic              w_fifo_valid;
  logic              w_in_ready;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic [EW-1:0]     w_out;

  assign w_fifo_valid = (r_count != '0);
  assign w_in_ready   = (r_count != CW'(DEPTH)) && (r_state == RUN);

`ifdef HEADER_DISPATCH_BYPASS_EN
  // Empty and both sides ready: hand the descriptor straight through, skipping storage.
  assign w_bypass  = (r_state == RUN) && !w_fifo_valid && in_valid && out_ready;
  assign out_valid = w_fifo_valid || w_bypass;
  assign w_out     = w_bypass ? {in_pdr_id, in_header, in_bitmap}
                              : (w_fifo_valid ? r_mem[r_rptr] : '0);
`else
  assign w_bypass  = 1'b0;
  assign out_valid = w_fifo_valid;
  assign w_out     = w_fifo_valid ? r_mem[r_rptr] : '0;
`endif

  assign w_push = in_valid && w_in_ready && !w_bypass;
  assign w_pop  = w_fifo_valid && out_ready;

  assign in_ready = w_in_ready;
  assign {out_pdr_id, out_header, out_bitmap} = w_out;
  assign count   = r_count;
  assign WE      = r_we;
  assign W_ADDR  = r_waddr;
  assign WD      = r_wd;
  assign cfg_ack = r_ack;

  // Storage is not reset; the cleared count makes stale entries invisible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {in_pdr_id, in_header, in_bitmap};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_ack   <= 1'b0;
      r_waddr <= '0;
      r_wd    <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      r_we    <= 1'b0;
      r_ack   <= 1'b0;
      r_waddr <= '0;
      r_wd    <= '0;
      // Rewrite only once every in-flight descriptor has left; the write pulse lasts one cycle.
      case (r_state)
        RUN:   if (cfg_req) r_state <= DRAIN;
        DRAIN: begin
          if (!w_fifo_valid) begin
            r_state <= WRITE;
            r_we    <= 1'b1;
            r_ack   <= 1'b1;
            r_waddr <= cfg_addr;
            r_wd    <= cfg_data;
          end
        end
        WRITE:   r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_header_dispatch.sv
// Scoreboard bench for header_dispatch: accepted descriptors are queued and checked in order on each pop.
module tb_header_dispatch;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 2;
  localparam int unsigned DL = 2;
  localparam int unsigned EW = AW + DW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_pdr_id;
  logic [DW-1:0] in_header;
  logic          in_bitmap;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pdr_id;
  logic [DW-1:0] out_header;
  logic          out_bitmap;
  logic          cfg_req;
  logic [AW-1:0] cfg_addr;
  logic [DW+3:0] cfg_data;
  logic          cfg_ack;
  logic          WE;
  logic [AW-1:0] W_ADDR;
  logic [DW+3:0] WD;
  logic [DL:0]   count;

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] sb [$];
  logic we_seen;

  header_dispatch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pdr_id(in_pdr_id),
    .in_header(in_header), .in_bitmap(in_bitmap),
    .out_valid(out_valid), .out_ready(out_ready), .out_pdr_id(out_pdr_id),
    .out_header(out_header), .out_bitmap(out_bitmap),
    .cfg_req(cfg_req), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
    .WE(WE), .W_ADDR(W_ADDR), .WD(WD), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs set; returns after the next falling edge.
  task automatic cycle();
    logic [EW-1:0] e;
    #1;
    if (in_valid && in_ready) sb.push_back({in_pdr_id, in_header, in_bitmap});
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("pop_while_empty", 64'(out_valid), 64'd0);
      else begin
        e = sb.pop_front();
        chk("out_desc", 64'({out_pdr_id, out_header, out_bitmap}), 64'(e));
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (rst) sb.delete();
    chk("count", 64'(count), 64'(sb.size()));
  endtask

  task automatic push(input int p, input logic [DW-1:0] h);
    in_valid  = 1'b1;
    in_pdr_id = AW'(p);
    in_header = h;
    in_bitmap = h[0];
    cycle();
    in_valid  = 1'b0;
  endtask

  task automatic drain_all();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) cycle();
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_count", 64'(count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pdr_id = '0; in_header = '0; in_bitmap = 1'b0;
    out_ready = 1'b0; cfg_req = 1'b0; cfg_addr = '0; cfg_data = '0;
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;

    // Reset values
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_header", 64'(out_header), 64'd0);
    chk("rst_we", 64'(WE), 64'd0);
    chk("rst_waddr", 64'(W_ADDR), 64'd0);
    chk("rst_wd", 64'(WD), 64'd0);
    chk("rst_ack", 64'(cfg_ack), 64'd0);

    // Fill to four with the output stalled, then offer a fifth
    for (int i = 0; i < 4; i++) begin
      chk("fill_in_ready", 64'(in_ready), 64'd1);
      push(i, DW'(32'h11 * (i + 1)));
      if (i == 0) chk("first_visible", 64'(out_valid), 64'd1);
    end
    chk("full_in_ready", 64'(in_ready), 64'd0);
    push(0, 32'h55);
    chk("full_count", 64'(count), 64'd4);
    chk("full_head", 64'(out_header), 64'h11);

    // Drain in order
    drain_all();

    // Streaming with one entry stored
    out_ready = 1'b0;
    push(1, 32'h100);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid  = 1'b1;
      in_pdr_id = AW'(i);
      in_header = DW'(32'h200 + i);
      in_bitmap = i[0];
      cycle();
      chk("stream_count", 64'(count), 64'd1);
    end
    drain_all();

    // Config interlock with two entries stored
    out_ready = 1'b0;
    push(2, 32'h300);
    push(3, 32'h301);
    cfg_req = 1'b1; cfg_addr = 2'd2; cfg_data = 36'h5_DEADBEEF;
    in_valid = 1'b1; in_pdr_id = 2'd0; in_header = 32'h302; in_bitmap = 1'b0;
    out_ready = 1'b1;
    chk("cfg_req_in_ready", 64'(in_ready), 64'd1);
    cycle();
    in_header = 32'h303;
    we_seen = 1'b0;
    for (int i = 0; i < 20 && !we_seen; i++) begin
      chk("drain_in_ready", 64'(in_ready), 64'd0);
      if (WE) begin
        we_seen = 1'b1;
        chk("wr_addr", 64'(W_ADDR), 64'd2);
        chk("wr_data", 64'(WD), 64'h5_DEADBEEF);
        chk("wr_ack", 64'(cfg_ack), 64'd1);
        chk("wr_fifo_empty", 64'(count), 64'd0);
      end
      cycle();
    end
    chk("wr_seen", 64'(we_seen), 64'd1);
    cfg_req = 1'b0; in_valid = 1'b0;
    chk("post_wr_we", 64'(WE), 64'd0);
    chk("post_wr_ack", 64'(cfg_ack), 64'd0);
    chk("post_wr_waddr", 64'(W_ADDR), 64'd0);
    chk("post_wr_wd", 64'(WD), 64'd0);
    chk("post_wr_in_ready", 64'(in_ready), 64'd1);

    // Request while empty still passes through DRAIN
    out_ready = 1'b0;
    cfg_req = 1'b1; cfg_addr = 2'd1; cfg_data = 36'hA_12345678;
    chk("empty_req_t0", 64'(WE), 64'd0);
    cycle();
    chk("empty_req_t1", 64'(WE), 64'd0);
    cycle();
    chk("empty_req_t2_we", 64'(WE), 64'd1);
    chk("empty_req_t2_addr", 64'(W_ADDR), 64'd1);
    chk("empty_req_t2_wd", 64'(WD), 64'hA_12345678);
    chk("empty_req_t2_ack", 64'(cfg_ack), 64'd1);
    cfg_req = 1'b0;
    cycle();
    chk("empty_req_t3_we", 64'(WE), 64'd0);

    // Reset while draining with three entries held
    push(0, 32'h400);
    push(1, 32'h401);
    push(2, 32'h402);
    cfg_req = 1'b1;
    cycle();
    chk("mid_drain_in_ready", 64'(in_ready), 64'd0);
    chk("mid_drain_count", 64'(count), 64'd3);
    rst = 1'b1; cfg_req = 1'b0;
    chk("mid_rst_we", 64'(WE), 64'd0);
    cycle();
    rst = 1'b0;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_header", 64'(out_header), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_no_we", 64'(WE), 64'd0);
      chk("mid_rst_no_ack", 64'(cfg_ack), 64'd0);
      cycle();
    end

    // Empty FIFO with both sides ready
    in_valid = 1'b1; in_pdr_id = 2'd3; in_header = 32'hABCD; in_bitmap = 1'b1;
    out_ready = 1'b1;
    #1;
`ifdef HEADER_DISPATCH_BYPASS_EN
    chk("bypass_out_valid", 64'(out_valid), 64'd1);
    chk("bypass_out_header", 64'(out_header), 64'hABCD);
    cycle();
    chk("bypass_count", 64'(count), 64'd0);
`else
    chk("no_bypass_out_valid", 64'(out_valid), 64'd0);
    cycle();
    chk("no_bypass_count", 64'(count), 64'd1);
    chk("no_bypass_header", 64'(out_header), 64'hABCD);
`endif
    drain_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
